prog_clock_div: RTL and testbench
=================================

PROG_CLOCK_DIV -- requirements
Module: prog_clock_div

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 17, width of each channel's divisor field.
REQ-003 SHALL have parameter CH_W, default 2, width of the channel select; 2**CH_W >= NUM_CH.
REQ-004 SHALL have ports: clock  in  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: cfg_valid  in  1  config request; cfg_ready  out  1  config accept.
REQ-007 SHALL have ports: cfg_ch  in  CH_W  target channel; cfg_div  in  DIV_W  divisor value D; cfg_en  in  1  channel enable.
REQ-008 SHALL have ports: div_clock  out  NUM_CH  registered divided clocks, one bit per channel.
REQ-009 SHALL have ports: cfg_err  out  1  one-cycle pulse on an accepted request with cfg_ch >= NUM_CH.

Function
REQ-010 SHALL run one counter per channel: 0..D, then wrap to 0; each wrap toggles div_clock[ch], giving period 2*(D+1) clocks at 50% duty.
REQ-011 SHALL treat D=0 as toggling every cycle (period 2); D = 2**DIV_W-1 as the maximum period, with no overflow.
REQ-012 SHALL accept a request when cfg_valid && cfg_ready; a transfer occurs in that cycle only.
REQ-013 SHALL drive cfg_ready low while the channel selected by cfg_ch holds a pending update, and high otherwise.
REQ-014 SHALL shadow an accepted D/enable for an enabled channel, and apply it at that channel's next wrap (glitch-free); pending clears in the same cycle.
REQ-015 SHALL apply an accepted update to a disabled channel in the cycle after acceptance; the counter starts at 0 with div_clock low.
REQ-016 SHALL, on applying cfg_en=0, clear the counter to 0 and force div_clock[ch] low one cycle after the apply point; the disabled channel then holds.
REQ-017 SHALL pulse cfg_err one cycle after an accepted out-of-range cfg_ch and change no channel state.
REQ-018 SHALL, if a second request for the same channel is presented while pending, hold it off with cfg_ready=0 (no overwrite); requests to other channels proceed.
REQ-019 SHALL keep channels fully independent; a wrap in one channel never affects another.

Reset
REQ-020 SHALL, on reset low, immediately clear all counters, shadow registers and pending flags, drive div_clock to all-zero and cfg_err to 0, and set every channel enabled with D=0.
REQ-021 SHALL, on reset low mid-operation, discard any pending update; outputs restart from 0 on the first clock after release.

Configuration
REQ-022 SHALL compile in, under macro PROG_CLOCK_DIV_TICK_EN, an extra output tick  out  NUM_CH; tick[ch] pulses high for one clock in every cycle where channel ch wraps (rate clock/(D+1)), and is 0 under reset or when disabled.
REQ-023 SHALL, without PROG_CLOCK_DIV_TICK_EN, omit the tick port and its logic; all other behaviour is identical.

Structure
REQ-024 SHALL place default NUM_CH/DIV_W/CH_W constants and the channel state encoding (IDLE, RUN, PENDING) in shared package prog_clock_div_pkg.
REQ-025 SHALL implement one channel as sub-module prog_clock_div_ch (counter, shadow, pending, output flop), instantiated NUM_CH times by generate.

Verification
REQ-026 SHALL cover: reset release with default config -> every div_clock toggles every clock (period 2), and cfg_ready=1.
REQ-027 SHALL cover: ch1 set to D=4 while running -> old period completes; the new period is 10 clocks, starting at the first wrap after acceptance; there are no runt pulses.
REQ-028 SHALL cover: ch2 disabled, then re-enabled with D=2 -> div_clock[2] low and held; one cycle after the enable is accepted it starts at 0, then rises after 3 clocks, period 6.
REQ-029 SHALL cover: two back-to-back requests to ch0 with D=1000 -> second is held (cfg_ready=0) until the first applies; a ch3 request in between is accepted immediately.
REQ-030 SHALL cover: cfg_ch=5 with NUM_CH=4 -> cfg_err pulses one cycle; all channels are unchanged.
REQ-031 SHALL cover: reset asserted mid-period with an update pending -> outputs are 0 immediately; after release the pending update is gone and the divisor is D=0.

Source files
------------

// File: rtl/prog_clock_div_pkg.sv
// Shared constants and channel state encoding for the programmable clock divider.
package prog_clock_div_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DIV_W_DEF  = 17;
  localparam int CH_W_DEF   = 2;

  // IDLE    : channel disabled, output held low, no update waiting
  // RUN     : channel counting, no update waiting
  // PENDING : an accepted update sits in the shadow registers
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } ch_state_e;

  // True when a channel select addresses an implemented channel.
  function automatic logic ch_in_range(input int unsigned ch, input int unsigned num_ch);
    return ch < num_ch;
  endfunction

endpackage

// File: rtl/prog_clock_div_ch.sv
// One divider channel: wrap counter, shadow divisor/enable, pending flag and
// registered divided-clock output. Optional per-wrap tick output is compiled
// in when PROG_CLOCK_DIV_TICK_EN is defined.
module prog_clock_div_ch
  import prog_clock_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             en_i,
  output logic             pend_o,
`ifdef PROG_CLOCK_DIV_TICK_EN
  output logic             tick_o,
`endif
  output logic             div_clk_o
);

  ch_state_e        state_q;
  logic             en_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] sdiv_q;
  logic             sen_q;
  logic             clk_q;
  logic             wrap;

  // The counter compares against D before incrementing, so it never exceeds
  // D and the all-ones divisor cannot overflow.
  assign cnt_d = cnt_q + DIV_W'(1);
  assign wrap  = en_q && (cnt_q == div_q);

  // Channel FSM: counts, captures updates into the shadow, and applies them
  // either at the next wrap (running) or on the following cycle (disabled).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      en_q    <= 1'b1;
      div_q   <= '0;
      cnt_q   <= '0;
      sdiv_q  <= '0;
      sen_q   <= 1'b1;
      clk_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wr_i) begin
            sdiv_q  <= div_i;
            sen_q   <= en_i;
            state_q <= PENDING;
          end
        end
        RUN: begin
          if (wrap) begin
            cnt_q <= '0;
            clk_q <= ~clk_q;
          end else begin
            cnt_q <= cnt_d;
          end
          if (wr_i) begin
            sdiv_q  <= div_i;
            sen_q   <= en_i;
            state_q <= PENDING;
          end
        end
        PENDING: begin
          // A running channel switches only on a wrap so the half-period in
          // flight always completes; a disabled one has nothing to protect.
          if (!en_q || wrap) begin
            div_q   <= sdiv_q;
            en_q    <= sen_q;
            cnt_q   <= '0;
            clk_q   <= (en_q && sen_q) ? ~clk_q : 1'b0;
            state_q <= sen_q ? RUN : IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
          cnt_q   <= '0;
          clk_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PROG_CLOCK_DIV_TICK_EN
  logic tick_q;

  // Registered wrap strobe, aligned with the divided-clock transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
    end
  end

  assign tick_o = tick_q;
`endif

  assign pend_o    = (state_q == PENDING);
  assign div_clk_o = clk_q;

endmodule

// File: rtl/prog_clock_div.sv
// Programmable multi-channel clock divider. Each channel produces a 50% duty
// clock of period 2*(D+1); updates are handed over through a valid/ready
// config port and applied glitch-free. Define PROG_CLOCK_DIV_TICK_EN to add
// the per-channel wrap tick output.
module prog_clock_div
  import prog_clock_div_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int CH_W   = CH_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] div_clock,
`ifdef PROG_CLOCK_DIV_TICK_EN
  output logic [NUM_CH-1:0] tick,
`endif
  output logic              cfg_err
);

  localparam int CH_SPAN = 2 ** CH_W;

  logic [NUM_CH-1:0]  pend;
  logic [CH_SPAN-1:0] pend_ext;
  logic               ch_ok;
  logic               accept;
  logic               cfg_err_q;

  // Unimplemented channel codes read as "not pending", so out-of-range
  // requests are always accepted and reported through cfg_err.
  assign pend_ext  = CH_SPAN'(pend);
  assign cfg_ready = ~pend_ext[cfg_ch];
  assign ch_ok     = ch_in_range(32'(cfg_ch), 32'(NUM_CH));
  assign accept    = cfg_valid && cfg_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr;

    assign wr = accept && ch_ok && (cfg_ch == CH_W'(g));

    prog_clock_div_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk_i    (clock),
      .rst_ni   (reset),
      .wr_i     (wr),
      .div_i    (cfg_div),
      .en_i     (cfg_en),
      .pend_o   (pend[g]),
`ifdef PROG_CLOCK_DIV_TICK_EN
      .tick_o   (tick[g]),
`endif
      .div_clk_o(div_clock[g])
    );
  end

  // One-cycle error strobe for an accepted request to a missing channel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= accept && !ch_ok;
    end
  end

  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_prog_clock_div.sv
// Scoreboard bench for prog_clock_div (4 channels, 10-bit divisor, 3-bit select).
module tb_prog_clock_div;

  localparam int NCH = 4;
  localparam int DW  = 10;
  localparam int CW  = 3;

  logic          clock;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [DW-1:0] cfg_div;
  logic          cfg_en;
  logic [NCH-1:0] div_clock;
  logic          cfg_err;
`ifdef PROG_CLOCK_DIV_TICK_EN
  logic [NCH-1:0] tick;
`endif

  prog_clock_div #(
    .NUM_CH(NCH),
    .DIV_W (DW),
    .CH_W  (CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_en   (cfg_en),
    .div_clock(div_clock),
`ifdef PROG_CLOCK_DIV_TICK_EN
    .tick     (tick),
`endif
    .cfg_err  (cfg_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [NCH-1:0] div;
    logic           err;
    logic           rdy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: each channel is described by the level it had when it
  // last (re)started, cycles elapsed since then, and its divisor. The output
  // is that level flipped once per completed D+1 cycles.
  int m_t[NCH];
  int m_d[NCH];
  int m_sd[NCH];
  bit m_en[NCH];
  bit m_lvl0[NCH];
  bit m_pend[NCH];
  bit m_sen[NCH];
  bit m_err;
  bit in_reset;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_t[c] = 0; m_d[c] = 0; m_sd[c] = 0;
      m_en[c] = 1'b1; m_lvl0[c] = 1'b0; m_pend[c] = 1'b0; m_sen[c] = 1'b1;
    end
    m_err = 1'b0;
  endfunction

  function automatic bit m_level(int c);
    if (!m_en[c]) return 1'b0;
    return m_lvl0[c] ^ (((m_t[c] / (m_d[c] + 1)) % 2) == 1);
  endfunction

  function automatic logic [NCH-1:0] m_outs();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_level(c);
    return v;
  endfunction

  function automatic void model_advance(bit acc, int ch, int d, bit e);
    for (int c = 0; c < NCH; c++) begin
      if (m_en[c]) begin
        int  tn;
        bit  lv;
        tn = m_t[c] + 1;
        if (m_pend[c] && (tn % (m_d[c] + 1)) == 0) begin
          lv        = m_lvl0[c] ^ (((tn / (m_d[c] + 1)) % 2) == 1);
          m_pend[c] = 1'b0;
          m_en[c]   = m_sen[c];
          m_d[c]    = m_sd[c];
          m_t[c]    = 0;
          m_lvl0[c] = m_sen[c] ? lv : 1'b0;
        end else begin
          m_t[c] = tn;
        end
      end else if (m_pend[c]) begin
        m_pend[c] = 1'b0;
        m_en[c]   = m_sen[c];
        m_d[c]    = m_sd[c];
        m_t[c]    = 0;
        m_lvl0[c] = 1'b0;
      end
    end
    if (acc && ch < NCH) begin
      m_pend[ch] = 1'b1;
      m_sd[ch]   = d;
      m_sen[ch]  = e;
    end
    m_err = acc && (ch >= NCH);
  endfunction

  // One clock of stimulus: drive inputs, queue the expected observation for
  // this cycle, then move the model across the coming rising edge.
  task automatic step(input logic v, input int ch, input int d, input logic e, output logic acc);
    exp_t x;
    logic rdy;
    @(negedge clock);
    cfg_valid = v;
    cfg_ch    = CW'(ch);
    cfg_div   = DW'(d);
    cfg_en    = e;
    rdy       = (ch >= NCH) ? 1'b1 : !m_pend[ch];
    x.div     = m_outs();
    x.err     = m_err;
    x.rdy     = rdy;
    exp_q.push_back(x);
    acc = v && rdy;
    if (!in_reset) model_advance(acc, ch, d, e);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(0, 5)), int'($urandom_range(0, 1023)), 1'b1, acc);
  endtask

  task automatic req(input int ch, input int d, input logic e, input int bound, input string name);
    logic acc;
    int   n;
    n = 0;
    do begin
      step(1'b1, ch, d, e, acc);
      n++;
    end while (!acc && n < bound);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL %s: request not accepted after %0d cycles, required acceptance", name, bound);
    end
  endtask

  task automatic async_reset(input string name);
    logic acc;
    @(negedge clock);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (div_clock !== '0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: div_clock=%b cfg_err=%b, required 0000 and 0", name, div_clock, cfg_err);
    end
    model_reset();
    in_reset = 1'b1;
    step(1'b0, 0, 0, 1'b1, acc);
    @(posedge clock);
    #1;
    reset    = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: compares the DUT outputs against each queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (div_clock !== e.div) begin
          errors++;
          $display("FAIL div_clock @%0t: got %b, required %b", $time, div_clock, e.div);
        end
        checks++;
        if (cfg_err !== e.err) begin
          errors++;
          $display("FAIL cfg_err @%0t: got %b, required %b", $time, cfg_err, e.err);
        end
        checks++;
        if (cfg_ready !== e.rdy) begin
          errors++;
          $display("FAIL cfg_ready @%0t: got %b, required %b (cfg_ch=%0d)", $time, cfg_ready, e.rdy, cfg_ch);
        end
      end
    end
  end

  initial begin : driver
    logic acc;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_en    = 1'b1;
    in_reset  = 1'b1;
    model_reset();
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (div_clock !== '0 || cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: div_clock=%b cfg_err=%b cfg_ready=%b, required 0000 0 1",
               div_clock, cfg_err, cfg_ready);
    end
    @(posedge clock);
    #1;
    reset    = 1'b1;
    in_reset = 1'b0;

    // Default configuration: every channel toggles each clock.
    idle(8);

    // Channel 1 retimed to D=4 while running.
    req(1, 4, 1'b1, 4, "ch1_d4");
    idle(30);

    // Channel 2 disabled, then re-enabled with D=2.
    req(2, 0, 1'b0, 4, "ch2_off");
    idle(8);
    req(2, 2, 1'b1, 4, "ch2_on");
    idle(20);

    // Back-to-back requests to channel 0; channel 3 slips in between.
    req(0, 1000, 1'b1, 4, "ch0_first");
    step(1'b1, 0, 1000, 1'b1, acc);
    req(3, 3, 1'b1, 1, "ch3_between");
    req(0, 1000, 1'b1, 3000, "ch0_second");
    req(0, 5, 1'b1, 3000, "ch0_third");
    idle(20);

    // Out-of-range channel select.
    req(5, 7, 1'b0, 1, "ch5_err");
    idle(6);

    // Largest divisor on channel 3: full 2048-cycle period.
    req(3, 1023, 1'b1, 20, "ch3_max");
    idle(2 * 1024 + 40);
    req(3, 0, 1'b1, 3000, "ch3_back");
    idle(10);

    // Reset with an update pending on channel 1.
    req(1, 50, 1'b1, 20, "ch1_pend");
    async_reset("reset_midrun");
    idle(12);

    // Randomised traffic, including disables and out-of-range selects.
    for (int i = 0; i < 600; i++) begin
      logic v;
      int   d;
      v = ($urandom_range(0, 99) < 30);
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 6));
      step(v, int'($urandom_range(0, 5)), d, ($urandom_range(0, 9) != 0), acc);
    end
    idle(4);

    @(negedge clock);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
